// File: rtl/escalonador_quantum.sv
// escalonador_quantum
// Round-robin quantum scheduler feeding the CPU program-counter logic.
// It counts retired user instructions. It requests a one-cycle context switch
// when a quantum expires, when a process issues I/O, or when a process ends.
// It keeps the resume PC of every user process in a table. It also presents
// the round-robin successor and that process's resume PC to the OS dispatcher.
//
// Ports
//   clock               system clock, rising edge
//   reset               synchronous, active-low
//   pc                  PC of the instruction presented by the CPU
//   avanca              instruction at pc retires this cycle
//   InstrucaIO          retiring user instruction is IN/OUT
//   fimProcesso         retiring user instruction ends the process
//   carrega/carrega_id  OS registers process carrega_id as active
//   troca_contexto      one-cycle context-switch request
//   pc_processo_trocado resume PC of the interrupted process (registered)
//   processo_atual      id owning pc (0 while in the OS)
//   proximo_processo    round-robin successor (0 if none)
//   pc_proximo          saved PC of the successor, or PC_ESCALONADOR
//   nenhum_ativo        no process is active
module escalonador_quantum #(
   parameter int          QUANTUM        = 8,
   parameter int          NUM_PROC       = 10,
   parameter int          PROC_SPAN      = 300,
   parameter logic [31:0] PC_ESCALONADOR = 32'd73
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        avanca,
   input  logic        InstrucaIO,
   input  logic        fimProcesso,
   input  logic        carrega,
   input  logic [3:0]  carrega_id,
   output logic        troca_contexto,
   output logic [31:0] pc_processo_trocado,
   output logic [3:0]  processo_atual,
   output logic [3:0]  proximo_processo,
   output logic [31:0] pc_proximo,
   output logic        nenhum_ativo
);

   localparam int CNT_W = $clog2(QUANTUM + 1);

   typedef enum logic [1:0] {OCIOSO, EXECUTANDO, EXPIRADO, TROCA} estado_t;

   estado_t          estado, proxEstado;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       atual;
   logic [3:0]       ultimo;
   logic [3:0]       idDoPc;
   logic [3:0]       base;
   logic [3:0]       prox;
   logic [NUM_PROC:1] ativo;
   logic [31:0]      pcSalvo [1:NUM_PROC];
   logic             salvaEn;
   logic [31:0]      salvaVal;
   logic             limpaAtivo;
   logic             carregaOk;

   assign carregaOk = carrega && (carrega_id >= 4'd1) && (carrega_id <= 4'(NUM_PROC));

   // floor(pc / PROC_SPAN) as a compare chain; PCs past the last process map to 0
   always_comb begin
      idDoPc = '0;
      for (int i = 1; i <= NUM_PROC; i++)
         if (pc >= 32'(i * PROC_SPAN)) idDoPc = 4'(i);
      if (pc >= 32'((NUM_PROC + 1) * PROC_SPAN)) idDoPc = '0;
   end

   // Next state; event priority is end > I/O > quantum expiry
   always_comb begin
      proxEstado = estado;
      salvaEn    = 1'b0;
      salvaVal   = pc;
      limpaAtivo = 1'b0;
      case (estado)
         OCIOSO:
            if (pc >= 32'(PROC_SPAN)) proxEstado = EXECUTANDO;
         EXECUTANDO:
            if (avanca && fimProcesso) begin
               limpaAtivo = 1'b1;
               proxEstado = TROCA;
            end else if (avanca && InstrucaIO) begin
               // resume after the I/O instruction
               salvaEn    = 1'b1;
               salvaVal   = pc + 32'd1;
               proxEstado = TROCA;
            end else if (avanca && (cnt == CNT_W'(QUANTUM - 1))) begin
               proxEstado = EXPIRADO;
            end else if (pc < 32'(PROC_SPAN)) begin
               proxEstado = OCIOSO;
            end
         EXPIRADO: begin
            // the CPU has already moved pc to the next instruction to run
            salvaEn    = 1'b1;
            proxEstado = TROCA;
         end
         TROCA:
            proxEstado = OCIOSO;
         default:
            proxEstado = OCIOSO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado              <= OCIOSO;
         cnt                 <= '0;
         atual               <= '0;
         ultimo              <= '0;
         ativo               <= '0;
         pc_processo_trocado <= '0;
      end else begin
         estado <= proxEstado;
         case (estado)
            OCIOSO: begin
               cnt   <= '0;
               atual <= idDoPc;
            end
            EXECUTANDO:
               if (avanca) cnt <= cnt + CNT_W'(1);
            TROCA: begin
               cnt    <= '0;
               ultimo <= atual;
            end
            default: ;
         endcase
         if (salvaEn) pc_processo_trocado <= salvaVal;
         if (carregaOk) ativo[carrega_id] <= 1'b1;
         // placed after the load so a same-cycle end of the same id wins
         if (limpaAtivo && (atual != 4'd0)) ativo[atual] <= 1'b0;
      end
   end

   // Resume-PC table; validity is carried by ativo, so no reset here
   always_ff @(posedge clock) begin
      if (carregaOk) pcSalvo[carrega_id] <= 32'(int'(carrega_id) * PROC_SPAN);
      if (salvaEn && (atual != 4'd0)) pcSalvo[atual] <= salvaVal;
   end

   // Successor scan base+1 .. NUM_PROC, 1 .. base. Iterating downward lets the
   // nearest active id overwrite the farther ones, so base itself is picked
   // only when it is the sole active process.
   always_comb begin
      int cand;
      base = (estado == OCIOSO) ? ultimo : atual;
      prox = '0;
      for (int k = NUM_PROC; k >= 1; k--) begin
         cand = int'(base) + k;
         if (cand > NUM_PROC) cand = cand - NUM_PROC;
         if (ativo[4'(cand)]) prox = 4'(cand);
      end
   end

   assign troca_contexto   = (estado == TROCA);
   assign processo_atual   = (estado == OCIOSO) ? 4'd0 : atual;
   assign proximo_processo = prox;
   assign nenhum_ativo     = ~|ativo;
   assign pc_proximo       = (prox == 4'd0) ? PC_ESCALONADOR : pcSalvo[prox];

endmodule

// File: tb/tb_escalonador_quantum.sv
// tb_escalonador_quantum
// Directed bench for escalonador_quantum: reset, quantum expiry, I/O switch,
// process end, simultaneous I/O and end, halted CPU, and reset mid-switch.
module tb_escalonador_quantum;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        avanca, InstrucaIO, fimProcesso, carrega;
   logic [3:0]  carrega_id;
   logic        troca_contexto;
   logic [31:0] pc_processo_trocado;
   logic [3:0]  processo_atual;
   logic [3:0]  proximo_processo;
   logic [31:0] pc_proximo;
   logic        nenhum_ativo;

   int nComp = 0;
   int nFail = 0;

   escalonador_quantum dut (
      .clock              (clock),
      .reset              (reset),
      .pc                 (pc),
      .avanca             (avanca),
      .InstrucaIO         (InstrucaIO),
      .fimProcesso        (fimProcesso),
      .carrega            (carrega),
      .carrega_id         (carrega_id),
      .troca_contexto     (troca_contexto),
      .pc_processo_trocado(pc_processo_trocado),
      .processo_atual     (processo_atual),
      .proximo_processo   (proximo_processo),
      .pc_proximo         (pc_proximo),
      .nenhum_ativo       (nenhum_ativo)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0; pc = 32'd0; avanca = 1'b0; InstrucaIO = 1'b0;
      fimProcesso = 1'b0; carrega = 1'b0; carrega_id = 4'd0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic load(input logic [3:0] id);
      carrega = 1'b1; carrega_id = id;
      tick();
      carrega = 1'b0; carrega_id = 4'd0;
   endtask

   task automatic retire(input int n);
      for (int i = 0; i < n; i++) begin
         avanca = 1'b1;
         tick();
         pc = pc + 32'd1;
         avanca = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL reset_troca: got %0b want 0", troca_contexto); end
      nComp++; if (nenhum_ativo !== 1'b1) begin nFail++; $display("FAIL reset_nenhum: got %0b want 1", nenhum_ativo); end
      nComp++; if (pc_proximo !== 32'd73) begin nFail++; $display("FAIL reset_pc_proximo: got %0d want 73", pc_proximo); end
      nComp++; if (processo_atual !== 4'd0) begin nFail++; $display("FAIL reset_atual: got %0d want 0", processo_atual); end
      nComp++; if (proximo_processo !== 4'd0) begin nFail++; $display("FAIL reset_proximo: got %0d want 0", proximo_processo); end
      nComp++; if (pc_processo_trocado !== 32'd0) begin nFail++; $display("FAIL reset_pc_trocado: got %0d want 0", pc_processo_trocado); end
      // out-of-range ids are ignored
      load(4'd0);
      load(4'd11);
      nComp++; if (nenhum_ativo !== 1'b1) begin nFail++; $display("FAIL bad_id_ignored: got %0b want 1", nenhum_ativo); end
   endtask

   task automatic test_expiry();
      do_reset();
      load(4'd1);
      load(4'd3);
      pc = 32'd300;
      tick();
      nComp++; if (processo_atual !== 4'd1) begin nFail++; $display("FAIL exp_atual: got %0d want 1", processo_atual); end
      for (int i = 1; i <= 8; i++) begin
         retire(1);
         nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL exp_early_pulse: retire %0d got %0b want 0", i, troca_contexto); end
      end
      tick();
      nComp++; if (troca_contexto !== 1'b1) begin nFail++; $display("FAIL exp_pulse: got %0b want 1", troca_contexto); end
      nComp++; if (pc_processo_trocado !== 32'd308) begin nFail++; $display("FAIL exp_pc_trocado: got %0d want 308", pc_processo_trocado); end
      nComp++; if (proximo_processo !== 4'd3) begin nFail++; $display("FAIL exp_proximo: got %0d want 3", proximo_processo); end
      nComp++; if (pc_proximo !== 32'd900) begin nFail++; $display("FAIL exp_pc_proximo: got %0d want 900", pc_proximo); end
      pc = 32'd73;
      tick();
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL exp_pulse_width: got %0b want 0", troca_contexto); end
      nComp++; if (processo_atual !== 4'd0) begin nFail++; $display("FAIL exp_idle_atual: got %0d want 0", processo_atual); end
      nComp++; if (proximo_processo !== 4'd3) begin nFail++; $display("FAIL exp_idle_proximo: got %0d want 3", proximo_processo); end
      nComp++; if (pc_processo_trocado !== 32'd308) begin nFail++; $display("FAIL exp_pc_stable: got %0d want 308", pc_processo_trocado); end
   endtask

   task automatic test_io();
      do_reset();
      load(4'd1);
      load(4'd3);
      pc = 32'd905;
      tick();
      nComp++; if (processo_atual !== 4'd3) begin nFail++; $display("FAIL io_atual: got %0d want 3", processo_atual); end
      avanca = 1'b1; InstrucaIO = 1'b1;
      tick();
      avanca = 1'b0; InstrucaIO = 1'b0;
      nComp++; if (troca_contexto !== 1'b1) begin nFail++; $display("FAIL io_pulse: got %0b want 1", troca_contexto); end
      nComp++; if (pc_processo_trocado !== 32'd906) begin nFail++; $display("FAIL io_pc_trocado: got %0d want 906", pc_processo_trocado); end
      nComp++; if (proximo_processo !== 4'd1) begin nFail++; $display("FAIL io_wrap: got %0d want 1", proximo_processo); end
      nComp++; if (pc_proximo !== 32'd300) begin nFail++; $display("FAIL io_pc_proximo: got %0d want 300", pc_proximo); end
      pc = 32'd73;
      tick();
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL io_pulse_width: got %0b want 0", troca_contexto); end
      // run id 1 and end it, exposing the saved PC of id 3
      pc = 32'd300;
      tick();
      avanca = 1'b1; fimProcesso = 1'b1;
      tick();
      avanca = 1'b0; fimProcesso = 1'b0;
      nComp++; if (troca_contexto !== 1'b1) begin nFail++; $display("FAIL io_end_pulse: got %0b want 1", troca_contexto); end
      nComp++; if (proximo_processo !== 4'd3) begin nFail++; $display("FAIL io_end_proximo: got %0d want 3", proximo_processo); end
      nComp++; if (pc_proximo !== 32'd906) begin nFail++; $display("FAIL io_saved_pc3: got %0d want 906", pc_proximo); end
      nComp++; if (pc_processo_trocado !== 32'd906) begin nFail++; $display("FAIL io_end_no_save: got %0d want 906", pc_processo_trocado); end
      pc = 32'd73;
      tick();
   endtask

   task automatic test_fim();
      do_reset();
      load(4'd2);
      pc = 32'd640;
      tick();
      nComp++; if (processo_atual !== 4'd2) begin nFail++; $display("FAIL fim_atual: got %0d want 2", processo_atual); end
      // reload of the same id in the same cycle must lose to the clear
      avanca = 1'b1; fimProcesso = 1'b1; carrega = 1'b1; carrega_id = 4'd2;
      tick();
      avanca = 1'b0; fimProcesso = 1'b0; carrega = 1'b0; carrega_id = 4'd0;
      nComp++; if (troca_contexto !== 1'b1) begin nFail++; $display("FAIL fim_pulse: got %0b want 1", troca_contexto); end
      nComp++; if (nenhum_ativo !== 1'b1) begin nFail++; $display("FAIL fim_nenhum: got %0b want 1", nenhum_ativo); end
      nComp++; if (pc_proximo !== 32'd73) begin nFail++; $display("FAIL fim_pc_proximo: got %0d want 73", pc_proximo); end
      nComp++; if (proximo_processo !== 4'd0) begin nFail++; $display("FAIL fim_proximo: got %0d want 0", proximo_processo); end
      pc = 32'd73;
      tick();
   endtask

   task automatic test_io_and_fim();
      do_reset();
      load(4'd4);
      load(4'd5);
      pc = 32'd1200;
      tick();
      retire(7);
      avanca = 1'b1; InstrucaIO = 1'b1; fimProcesso = 1'b1;
      tick();
      avanca = 1'b0; InstrucaIO = 1'b0; fimProcesso = 1'b0;
      nComp++; if (troca_contexto !== 1'b1) begin nFail++; $display("FAIL both_pulse: got %0b want 1", troca_contexto); end
      nComp++; if (pc_processo_trocado !== 32'd0) begin nFail++; $display("FAIL both_no_save: got %0d want 0", pc_processo_trocado); end
      nComp++; if (proximo_processo !== 4'd5) begin nFail++; $display("FAIL both_proximo: got %0d want 5", proximo_processo); end
      nComp++; if (pc_proximo !== 32'd1500) begin nFail++; $display("FAIL both_pc_proximo: got %0d want 1500", pc_proximo); end
      pc = 32'd73;
      tick();
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL both_single_1: got %0b want 0", troca_contexto); end
      tick();
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL both_single_2: got %0b want 0", troca_contexto); end
   endtask

   task automatic test_halt();
      do_reset();
      load(4'd1);
      pc = 32'd300;
      tick();
      retire(5);
      for (int i = 0; i < 20; i++) begin
         tick();
         nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL halt_no_pulse: cycle %0d got %0b want 0", i, troca_contexto); end
      end
      for (int i = 1; i <= 3; i++) begin
         retire(1);
         nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL halt_retire: retire %0d got %0b want 0", i, troca_contexto); end
      end
      tick();
      nComp++; if (troca_contexto !== 1'b1) begin nFail++; $display("FAIL halt_pulse: got %0b want 1", troca_contexto); end
      nComp++; if (pc_processo_trocado !== 32'd308) begin nFail++; $display("FAIL halt_pc_trocado: got %0d want 308", pc_processo_trocado); end
      pc = 32'd73;
      tick();
   endtask

   task automatic test_reset_mid_switch();
      do_reset();
      load(4'd1);
      pc = 32'd300;
      tick();
      retire(8);
      // now in EXPIRADO
      reset = 1'b0;
      tick();
      reset = 1'b1; pc = 32'd73;
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL rst_mid_troca: got %0b want 0", troca_contexto); end
      nComp++; if (pc_processo_trocado !== 32'd0) begin nFail++; $display("FAIL rst_mid_pc_trocado: got %0d want 0", pc_processo_trocado); end
      nComp++; if (nenhum_ativo !== 1'b1) begin nFail++; $display("FAIL rst_mid_nenhum: got %0b want 1", nenhum_ativo); end
      nComp++; if (pc_proximo !== 32'd73) begin nFail++; $display("FAIL rst_mid_pc_proximo: got %0d want 73", pc_proximo); end
      nComp++; if (processo_atual !== 4'd0) begin nFail++; $display("FAIL rst_mid_atual: got %0d want 0", processo_atual); end
      tick();
      nComp++; if (troca_contexto !== 1'b0) begin nFail++; $display("FAIL rst_mid_late_pulse: got %0b want 0", troca_contexto); end
   endtask

   initial begin
      test_reset();
      test_expiry();
      test_io();
      test_fim();
      test_io_and_fim();
      test_halt();
      test_reset_mid_switch();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
      $finish;
   end

endmodule

// File: doc/escalonador_quantum.md
# escalonador_quantum

Round-robin quantum scheduler that sits directly upstream of the CPU's program-counter logic. It counts retired user-process instructions and raises a one-cycle `troca_contexto` when a quantum expires, a process issues I/O, or a process ends. It captures the resume PC of the interrupted process in a per-process table. It also presents the next process and its resume PC to the OS save/dispatch routine.

## Interface
- `QUANTUM`, 8: retired instructions per time slice (≥2)
- `NUM_PROC`, 10: user processes, ids 1..NUM_PROC (id 0 = OS)
- `PROC_SPAN`, 300: instruction-memory words per process; process i occupies [i·PROC_SPAN, (i+1)·PROC_SPAN)
- `PC_ESCALONADOR`, 73: PC presented when no process is active
- `clock`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low reset
- `pc`  in  32  PC of the instruction currently presented by the CPU
- `avanca`  in  1  the instruction at `pc` retires this cycle (low while halted)
- `InstrucaIO`  in  1  the user instruction at `pc` is IN/OUT (sampled with `avanca`)
- `fimProcesso`  in  1  the user instruction at `pc` ends the process (sampled with `avanca`)
- `carrega`  in  1  register a process as active (OS load)
- `carrega_id`  in  4  id to register
- `troca_contexto`  out  1  one-cycle context-switch request to CPU
- `pc_processo_trocado`  out  32  resume PC of the interrupted process
- `processo_atual`  out  4  id owning `pc` (0 while in OS)
- `proximo_processo`  out  4  round-robin successor (0 if none)
- `pc_proximo`  out  32  saved PC of `proximo_processo`, or `PC_ESCALONADOR`
- `nenhum_ativo`  out  1  no active process

## Operation
- Table: `ativo[1..NUM_PROC]` flags, `pc_salvo[1..NUM_PROC]` 32-bit entries. Quantum counter width is ceil(log2(QUANTUM+1)).
- States: OCIOSO, EXECUTANDO, EXPIRADO, TROCA.
- OCIOSO: `processo_atual`=0. When `pc` ≥ PROC_SPAN, go to EXECUTANDO. `processo_atual` is loaded with floor(pc/PROC_SPAN) through a range-compare chain, clamped to 0 if above NUM_PROC. Counter is cleared.
- EXECUTANDO: each `avanca` increments the counter. Event priority is fimProcesso > InstrucaIO > expiry.
  - `fimProcesso`&`avanca`: clear `ativo[atual]`, leave `pc_salvo` untouched, go to TROCA.
  - `InstrucaIO`&`avanca`: `pc_salvo[atual]` and `pc_processo_trocado` ← pc+1, go to TROCA.
  - `avanca` with counter==QUANTUM-1: go to EXPIRADO.
  - `pc` < PROC_SPAN without an event: go to OCIOSO.
- EXPIRADO: wait for the CPU's PC update. `pc_salvo[atual]` and `pc_processo_trocado` ← current `pc`, then go to TROCA.
- TROCA: `troca_contexto`=1 for exactly this cycle. The counter clears. Next state is OCIOSO.
- Successor (combinational on the table): the first active id scanning atual+1 … NUM_PROC, 1 … atual, wrapping. Current id is chosen only if it is the sole active process. From OCIOSO the scan starts at id 1 after the last switched-out id.
- `carrega` with 1≤id≤NUM_PROC sets `ativo[id]`=1 and `pc_salvo[id]`=id·PROC_SPAN. Other ids are ignored. Same-cycle `carrega` and `fimProcesso` on one id: the clear wins.

## Timing
- Reset (sampled low at an edge) puts every output at 0, except `pc_proximo`=PC_ESCALONADOR and `nenhum_ativo`=1. All `ativo` bits are 0, state is OCIOSO, counter is 0.
- Reset takes effect mid-switch, and TROCA is abandoned.
- Latency to `troca_contexto`:
  - Expiry: 2 cycles after the QUANTUM-th `avanca` (through EXPIRADO).
  - I/O or end: 1 cycle after the qualifying `avanca`.
- `pc_processo_trocado` is registered and stable from the `troca_contexto` cycle until the next switch.
- `avanca` low freezes the counter; a halted CPU never expires a quantum.
- `proximo_processo`/`pc_proximo` reflect table updates the cycle after the write edge.

## Test plan
- Reset low 2 cycles → `troca_contexto`=0, `nenhum_ativo`=1, `pc_proximo`=73, `processo_atual`=0.
- Load ids 1,3; pc=300, `avanca` every cycle → `troca_contexto` pulses 1 cycle, 2 cycles after the 8th retire. `pc_processo_trocado`=pc at EXPIRADO (308 for linear code). `proximo_processo`=3, `pc_proximo`=900.
- Load ids 1,3; id 3 at pc=905 issues `InstrucaIO` → pulse 1 cycle later, `pc_salvo[3]`=906, `proximo_processo`=1, wrap verified.
- Only id 2 active, `fimProcesso` at pc=640 → pulse, `ativo[2]`=0, `nenhum_ativo`=1, `pc_proximo`=73.
- Same cycle `InstrucaIO`&`fimProcesso` at count 7 → end path taken, single pulse, no save.
- `avanca` low for 20 cycles at count 5, then 3 retires → switch only after the 3rd; reset asserted during EXPIRADO → no pulse, all outputs at reset values.
